// File: rtl/replica_pkg.sv
// Shared definitions for the anneal scheduler: FSM state encoding and the fixed
// width of the per-segment iteration count.
package replica_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT_HI,
        WAIT_LO,
        STEP,
        FIN
    } sched_state_t;

    localparam int RUN_TIMES_W = 24;

endpackage

// File: rtl/anneal_scheduler_if.sv
// Handshake bundle between the schedule requester, the node controllers and the
// scheduler. The abort wire exists only when SCHED_ABORT_EN is defined.
interface anneal_scheduler_if
    import replica_pkg::*;
#(
    parameter int SEG_W  = 8,
    parameter int BETA_W = 32
);
    logic                   start;
    logic [SEG_W-1:0]       segment_num;
    logic [RUN_TIMES_W-1:0] segment_times;
    logic [BETA_W-1:0]      beta_init;
    logic [BETA_W-1:0]      beta_step;
    logic                   running;
`ifdef SCHED_ABORT_EN
    logic                   abort;
`endif
    logic                   beta_write;
    logic [BETA_W-1:0]      beta;
    logic                   run_write;
    logic [RUN_TIMES_W-1:0] run_times;
    logic [SEG_W-1:0]       segment_idx;
    logic                   busy;
    logic                   done;

    modport master (
`ifdef SCHED_ABORT_EN
        output abort,
`endif
        output start, segment_num, segment_times, beta_init, beta_step, running,
        input  beta_write, beta, run_write, run_times, segment_idx, busy, done
    );

    modport slave (
`ifdef SCHED_ABORT_EN
        input  abort,
`endif
        input  start, segment_num, segment_times, beta_init, beta_step, running,
        output beta_write, beta, run_write, run_times, segment_idx, busy, done
    );

endinterface

// File: rtl/sat_add.sv
// Unsigned adder that clamps to all-ones instead of wrapping on overflow.
module sat_add #(
    parameter int BETA_W = 32
) (
    input  logic [BETA_W-1:0] a_i,
    input  logic [BETA_W-1:0] b_i,
    output logic [BETA_W-1:0] sum_o
);
    logic [BETA_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o    = full_sum[BETA_W] ? '1 : full_sum[BETA_W-1:0];

endmodule

// File: rtl/anneal_scheduler.sv
// Steps an annealing schedule: per segment it publishes beta, kicks one node run
// and waits for it to drain. Defining SCHED_ABORT_EN adds an abort input.
module anneal_scheduler
    import replica_pkg::*;
#(
    parameter int SEG_W  = 8,
    parameter int BETA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    anneal_scheduler_if.slave bus
);
    sched_state_t           state_q, state_d;
    logic [SEG_W-1:0]       seg_num_q, seg_num_d;
    logic [SEG_W-1:0]       idx_q, idx_d;
    logic [RUN_TIMES_W-1:0] times_q, times_d;
    logic [BETA_W-1:0]      beta_q, beta_d;
    logic [BETA_W-1:0]      step_q, step_d;
    logic [BETA_W-1:0]      beta_next;
    logic                   last_seg;
    logic                   done_q;
`ifdef SCHED_ABORT_EN
    logic                   abort_pend_q, abort_pend_d;
`endif

    sat_add #(.BETA_W(BETA_W)) u_sat_add (
        .a_i   (beta_q),
        .b_i   (step_q),
        .sum_o (beta_next)
    );

    assign last_seg = (idx_q + SEG_W'(1)) == seg_num_q;

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        seg_num_d = seg_num_q;
        idx_d     = idx_q;
        times_d   = times_q;
        beta_d    = beta_q;
        step_d    = step_q;
`ifdef SCHED_ABORT_EN
        abort_pend_d = abort_pend_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    seg_num_d = bus.segment_num;
                    times_d   = bus.segment_times;
                    beta_d    = bus.beta_init;
                    step_d    = bus.beta_step;
                    idx_d     = '0;
                    state_d   = (bus.segment_num == '0) ? FIN : LOAD;
                end
            end
            LOAD:    state_d = (times_q == '0) ? STEP : KICK;
            KICK:    state_d = WAIT_HI;
            WAIT_HI: if (bus.running) state_d = WAIT_LO;
            WAIT_LO: if (!bus.running) state_d = STEP;
            STEP: begin
                if (last_seg) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + SEG_W'(1);
                    beta_d  = beta_next;
                    state_d = LOAD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SCHED_ABORT_EN
        // A node run in flight must drain, so abort in WAIT_LO is parked until running falls.
        if (state_q == IDLE) abort_pend_d = 1'b0;
        if (bus.abort && (state_q inside {LOAD, KICK, WAIT_HI, STEP})) begin
            state_d = FIN;
            idx_d   = idx_q;
            beta_d  = beta_q;
        end
        if (state_q == WAIT_LO) begin
            if (bus.abort) abort_pend_d = 1'b1;
            if (!bus.running && (abort_pend_q || bus.abort)) state_d = FIN;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            seg_num_q <= '0;
            idx_q     <= '0;
            times_q   <= '0;
            beta_q    <= '0;
            step_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_num_q <= seg_num_d;
            idx_q     <= idx_d;
            times_q   <= times_d;
            beta_q    <= beta_d;
            step_q    <= step_d;
            done_q    <= (state_q == FIN);
        end
    end

`ifdef SCHED_ABORT_EN
    always_ff @(posedge clk) begin
        if (reset) abort_pend_q <= 1'b0;
        else       abort_pend_q <= abort_pend_d;
    end
`endif

    assign bus.beta_write  = (state_q == LOAD);
    assign bus.run_write   = (state_q == KICK);
    assign bus.beta        = beta_q;
    assign bus.run_times   = times_q;
    assign bus.segment_idx = idx_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;

endmodule

// File: tb/tb_anneal_scheduler.sv
// Directed bench for anneal_scheduler with a transaction-level schedule model.
// The abort scenario is compiled in only when SCHED_ABORT_EN is defined.
module tb_anneal_scheduler;
    import replica_pkg::*;

    localparam int SEG_W  = 8;
    localparam int BETA_W = 32;
    localparam logic [BETA_W-1:0] BETA_MAX = '1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int n_checks = 0;
    int n_errors = 0;

    logic [BETA_W-1:0]      exp_beta[$];
    logic [RUN_TIMES_W-1:0] exp_times = '0;
    int node_dly[$];
    int node_len[$];
    int exp_bw_cyc = -1;
    int exp_rw_cyc = -1;
    int bw_cnt = 0, rw_cnt = 0, done_cnt = 0;
    int done_cyc = -1, fall_cyc = -1, start_cyc = 0;
    int b0, r0, d0;

    anneal_scheduler_if #(.SEG_W(SEG_W), .BETA_W(BETA_W)) bus ();

    anneal_scheduler #(.SEG_W(SEG_W), .BETA_W(BETA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Segment i uses init + i*step, clamped once it passes all-ones.
    function automatic logic [BETA_W-1:0] model_beta(input logic [BETA_W-1:0] init,
                                                      input logic [BETA_W-1:0] step,
                                                      input int i);
        logic [63:0] v;
        v = 64'(init) + 64'(step) * 64'(i);
        return (v > 64'(BETA_MAX)) ? BETA_MAX : v[BETA_W-1:0];
    endfunction

    task automatic expect_sched(input int segs, input int t,
                                input logic [BETA_W-1:0] bi, input logic [BETA_W-1:0] bs);
        for (int i = 0; i < segs; i++) exp_beta.push_back(model_beta(bi, bs, i));
        exp_times = RUN_TIMES_W'(t);
    endtask

    task automatic start_sched(input int n, input int t,
                               input logic [BETA_W-1:0] bi, input logic [BETA_W-1:0] bs);
        bus.segment_num   = SEG_W'(n);
        bus.segment_times = RUN_TIMES_W'(t);
        bus.beta_init     = bi;
        bus.beta_step     = bs;
        bus.start         = 1'b1;
        start_cyc  = cyc;
        exp_bw_cyc = (n != 0) ? cyc + 1 : -1;
        exp_rw_cyc = (n != 0 && t != 0) ? cyc + 2 : -1;
        b0 = bw_cnt; r0 = rw_cnt; d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
        @(negedge clk);
    endtask

    task automatic wait_running(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (bus.running) begin
                seen = 1'b1;
                break;
            end
        end
        check("running_seen", seen, 1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_beta"},        bus.beta,        0);
        check({tag, "_segment_idx"}, bus.segment_idx, 0);
        check({tag, "_run_times"},   bus.run_times,   0);
        check({tag, "_beta_write"},  bus.beta_write,  0);
        check({tag, "_run_write"},   bus.run_write,   0);
        check({tag, "_busy"},        bus.busy,        0);
        check({tag, "_done"},        bus.done,        0);
    endtask

    // Node controller model: after each run_write, rise after a delay, fall after a length.
    initial begin : node
        int d, l;
        bus.running = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.run_write && !reset) begin
                d = (node_dly.size() != 0) ? node_dly.pop_front() : 1;
                l = (node_len.size() != 0) ? node_len.pop_front() : 1;
                repeat (d) @(negedge clk);
                bus.running = 1'b1;
                repeat (l) @(negedge clk);
                bus.running = 1'b0;
                fall_cyc   = cyc;
                exp_bw_cyc = cyc + 2;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.beta_write || bus.run_write)
                    check("write_exclusive", bus.beta_write & bus.run_write, 0);
                if (bus.beta_write) begin
                    bw_cnt++;
                    check("beta_expected", exp_beta.size() != 0, 1);
                    if (exp_beta.size() != 0) check("beta", bus.beta, exp_beta.pop_front());
                    if (exp_bw_cyc >= 0) check("beta_write_latency", cyc, exp_bw_cyc);
                    exp_bw_cyc = -1;
                end
                if (bus.run_write) begin
                    rw_cnt++;
                    check("run_times", bus.run_times, exp_times);
                    if (exp_rw_cyc >= 0) check("run_write_latency", cyc, exp_rw_cyc);
                    exp_rw_cyc = -1;
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.start         = 1'b0;
        bus.segment_num   = '0;
        bus.segment_times = '0;
        bus.beta_init     = '0;
        bus.beta_step     = '0;
`ifdef SCHED_ABORT_EN
        bus.abort         = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // Three segments with node runs of varied delay and length.
        node_dly = '{1, 5, 20};
        node_len = '{4, 1, 6};
        expect_sched(3, 5, 100, 10);
        start_sched(3, 5, 100, 10);
        wait_done(400);
        check("s1_beta_writes", bw_cnt - b0, 3);
        check("s1_run_writes",  rw_cnt - r0, 3);
        check("s1_done_count",  done_cnt - d0, 1);
        check("s1_done_latency", done_cyc, fall_cyc + 3);
        check("s1_segment_idx", bus.segment_idx, 2);
        check("s1_final_beta",  bus.beta, 120);
        check("s1_done_pulse",  bus.done, 0);
        check("s1_busy",        bus.busy, 0);
        check("s1_model_left",  exp_beta.size(), 0);

        // Zero segments: straight to done, no writes.
        start_sched(0, 5, 7, 1);
        wait_done(20);
        check("s2_done_latency", done_cyc, start_cyc + 2);
        check("s2_beta_writes",  bw_cnt - b0, 0);
        check("s2_run_writes",   rw_cnt - r0, 0);

        // Zero iterations: beta published per segment, no node run.
        expect_sched(2, 0, 50, 3);
        start_sched(2, 0, 50, 3);
        wait_done(40);
        check("s3_done_latency", done_cyc, start_cyc + 6);
        check("s3_beta_writes",  bw_cnt - b0, 2);
        check("s3_run_writes",   rw_cnt - r0, 0);
        check("s3_segment_idx",  bus.segment_idx, 1);
        check("s3_final_beta",   bus.beta, 53);

        // Saturation of the beta increment.
        node_dly = '{2, 3};
        node_len = '{3, 2};
        expect_sched(2, 2, 32'hFFFF_FFF0, 32'h20);
        start_sched(2, 2, 32'hFFFF_FFF0, 32'h20);
        wait_done(100);
        check("s4_final_beta",  bus.beta, 32'hFFFF_FFFF);
        check("s4_run_writes",  rw_cnt - r0, 2);
        check("s4_model_left",  exp_beta.size(), 0);

        // A start while waiting for the node to finish must be dropped.
        node_dly = '{1};
        node_len = '{8};
        expect_sched(1, 4, 9, 1);
        start_sched(1, 4, 9, 1);
        wait_running(20);
        @(negedge clk);
        bus.segment_num = 5;
        bus.beta_init   = 999;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(60);
        repeat (10) @(negedge clk);
        check("s5_beta_writes", bw_cnt - b0, 1);
        check("s5_run_writes",  rw_cnt - r0, 1);
        check("s5_done_count",  done_cnt - d0, 1);
        check("s5_segment_idx", bus.segment_idx, 0);
        check("s5_busy",        bus.busy, 0);

        // Reset while waiting for the node to start: no done, all outputs cleared.
        node_dly = '{15};
        node_len = '{2};
        expect_sched(2, 3, 77, 1);
        start_sched(2, 3, 77, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_beta.delete();
        @(negedge clk);
        check_reset_outputs("mid");
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("s6_done_count",  done_cnt - d0, 0);
        check("s6_beta_writes", bw_cnt - b0, 1);
        check("s6_run_writes",  rw_cnt - r0, 1);
        check("s6_busy",        bus.busy, 0);

`ifdef SCHED_ABORT_EN
        // Abort while the node runs: wait for it to drain, then finish without another run.
        node_dly = '{1};
        node_len = '{12};
        expect_sched(1, 2, 5, 5);
        start_sched(3, 2, 5, 5);
        wait_running(20);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_done(60);
        repeat (5) @(negedge clk);
        check("s7_done_latency", done_cyc, fall_cyc + 2);
        check("s7_beta_writes",  bw_cnt - b0, 1);
        check("s7_run_writes",   rw_cnt - r0, 1);
        check("s7_done_count",   done_cnt - d0, 1);
        check("s7_segment_idx",  bus.segment_idx, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
